axis_scoreboard: RTL

- Synthesizable AXI-Stream checker that sits directly downstream of the exerciser and the DUT output.
- The exerciser pushes expected beats into an internal FIFO. The DUT output stream is accepted and compared beat-by-beat against the FIFO head.
- Errors, beat counts and timeouts are accumulated.
- On an end request from the exerciser, the block drains outstanding expectations and reports pass/fail. This replaces per-beat checking inside the test-vector loop.

---
 rtl/axis_scoreboard_pkg.sv | 33 +++
 rtl/axis_scoreboard_if.sv | 46 ++++
 rtl/scoreboard_fifo.sv | 49 ++++
 rtl/axis_scoreboard.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/axis_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// axis_scoreboard_pkg
// Shared types and constants for the AXI-Stream scoreboard:
//   exp_entry_t : one expected beat {data, mask, last}
//   state_t     : end-of-vector drain FSM states
//   LFSR_SEED / LFSR_TAPS / lfsrNext : sink backpressure generator
//     (only used when AXIS_SCOREBOARD_BACKPRESSURE_EN is defined)
// -----------------------------------------------------------------------------
package axis_scoreboard_pkg;

    localparam int DATA_W = 64;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] mask;
        logic              last;
    } exp_entry_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsrNext(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/axis_scoreboard_if.sv
// -----------------------------------------------------------------------------
// axis_scoreboard_if
// Bundles the scoreboard's streams and status:
//   exp_*      : expected-beat push stream from the exerciser
//   obs_*      : DUT output stream into the scoreboard sink
//   end_req / end_ack / pass : end-of-vector drain handshake
//   err_sticky, err_count, beat_count, first_err_beat, timeout : status
// modport master : exerciser / DUT side
// modport slave  : scoreboard side
// -----------------------------------------------------------------------------
interface axis_scoreboard_if #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 32
);
    logic              exp_valid;
    logic              exp_ready;
    logic [DATA_W-1:0] exp_data;
    logic [DATA_W-1:0] exp_mask;
    logic              exp_last;
    logic              obs_tvalid;
    logic              obs_tready;
    logic [DATA_W-1:0] obs_tdata;
    logic              obs_tlast;
    logic              end_req;
    logic              end_ack;
    logic              pass;
    logic              err_sticky;
    logic [CNT_W-1:0]  err_count;
    logic [CNT_W-1:0]  beat_count;
    logic [CNT_W-1:0]  first_err_beat;
    logic              timeout;

    modport master (
        output exp_valid, exp_data, exp_mask, exp_last,
        output obs_tvalid, obs_tdata, obs_tlast, end_req,
        input  exp_ready, obs_tready, end_ack, pass, err_sticky,
        input  err_count, beat_count, first_err_beat, timeout
    );

    modport slave (
        input  exp_valid, exp_data, exp_mask, exp_last,
        input  obs_tvalid, obs_tdata, obs_tlast, end_req,
        output exp_ready, obs_tready, end_ack, pass, err_sticky,
        output err_count, beat_count, first_err_beat, timeout
    );
endinterface

// File: rtl/scoreboard_fifo.sv
// -----------------------------------------------------------------------------
// scoreboard_fifo
// Synchronous FIFO of expected beats, head presented combinationally.
// Ports: clk, rst (sync active-high), push/wrData, pop/rdData,
//        flush (drops all entries), full, empty.
// Writes while full and reads while empty are ignored. Storage is not reset.
// -----------------------------------------------------------------------------
module scoreboard_fifo import axis_scoreboard_pkg::*; #(
    parameter int  DEPTH   = 16,
    parameter type entry_t = exp_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t wrData,
    input  logic   pop,
    output entry_t rdData,
    input  logic   flush,
    output logic   full,
    output logic   empty
);
    localparam int AW = $clog2(DEPTH);

    entry_t         mem [DEPTH];
    logic   [AW:0]  wrPtr;
    logic   [AW:0]  rdPtr;

    // Extra pointer bit distinguishes full from empty when addresses match.
    assign empty = (wrPtr == rdPtr);
    assign full  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign rdData = mem[rdPtr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (push && !full)
                wrPtr <= wrPtr + 1'b1;
            if (pop && !empty)
                rdPtr <= rdPtr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wrPtr[AW-1:0]] <= wrData;
    end
endmodule

// File: rtl/axis_scoreboard.sv
// -----------------------------------------------------------------------------
// axis_scoreboard
// AXI-Stream checker: the exerciser pushes expected beats {data, mask, last}
// into a FIFO; each accepted DUT beat is compared against the FIFO head.
// Errors, accepted beats and stall timeouts are accumulated; end_req starts a
// drain which finishes with a one-cycle end_ack/pass report.
// Ports: clk, rst (sync active-high), sb (axis_scoreboard_if.slave).
// Optional macro AXIS_SCOREBOARD_BACKPRESSURE_EN: obs_tready driven by a
// 16-bit LFSR; otherwise obs_tready is tied high.
// -----------------------------------------------------------------------------
module axis_scoreboard import axis_scoreboard_pkg::*; #(
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    axis_scoreboard_if.slave  sb
);
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] mask;
        logic              last;
    } entry_t;

    localparam int                 STALL_W   = $clog2(TIMEOUT + 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(TIMEOUT);

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t             state;
    state_t             stateNext;
    entry_t             head;
    entry_t             wrEntry;
    logic               fifoFull;
    logic               fifoEmpty;
    logic               readyEn;
    logic               expReady;
    logic               obsReady;
    logic               push;
    logic               accept;
    logic               mismatch;
    logic               stallInc;
    logic               timeoutHit;
    logic               errEvent;
    logic               flush;
    logic               endAck;
    logic               passOut;
    logic [STALL_W-1:0] stallCnt;
    logic               errSticky;
    logic               timeoutFlag;
    logic [CNT_W-1:0]   errCount;
    logic [CNT_W-1:0]   beatCount;
    logic [CNT_W-1:0]   firstErrBeat;

    // readyEn keeps exp_ready low while reset is held and for its last cycle.
    assign expReady = readyEn && !fifoFull;
    assign push     = sb.exp_valid && expReady;
    assign accept   = sb.obs_tvalid && obsReady;
    assign wrEntry  = '{data: sb.exp_data, mask: sb.exp_mask, last: sb.exp_last};

    scoreboard_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) uFifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .wrData (wrEntry),
        .pop    (accept && !fifoEmpty),
        .rdData (head),
        .flush  (flush),
        .full   (fifoFull),
        .empty  (fifoEmpty)
    );

`ifdef AXIS_SCOREBOARD_BACKPRESSURE_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst)
            lfsr <= LFSR_SEED;
        else
            lfsr <= lfsrNext(lfsr);
    end

    assign obsReady = lfsr[0];
    // A beat held off by our own tready is not a DUT stall.
    assign stallInc = !fifoEmpty && !accept && !(sb.obs_tvalid && !obsReady);
`else
    assign obsReady = 1'b1;
    assign stallInc = !fifoEmpty && !accept;
`endif

    assign mismatch   = (((sb.obs_tdata ^ head.data) & head.mask) != '0) ||
                        (sb.obs_tlast != head.last);
    // Fires once on the transition into TIMEOUT; the counter then holds.
    assign timeoutHit = stallInc && (stallCnt == STALL_MAX - 1'b1);
    assign errEvent   = (accept && (fifoEmpty || mismatch)) || timeoutHit;

    always_ff @(posedge clk) begin
        if (rst)
            stallCnt <= '0;
        else if (fifoEmpty || accept)
            stallCnt <= '0;
        else if (stallInc && stallCnt != STALL_MAX)
            stallCnt <= stallCnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            readyEn      <= 1'b0;
            errSticky    <= 1'b0;
            timeoutFlag  <= 1'b0;
            errCount     <= '0;
            beatCount    <= '0;
            firstErrBeat <= '0;
        end else begin
            readyEn <= 1'b1;
            if (accept)
                beatCount <= beatCount + 1'b1;
            if (timeoutHit)
                timeoutFlag <= 1'b1;
            if (errEvent) begin
                errCount  <= satInc(errCount);
                errSticky <= 1'b1;
                if (!errSticky)
                    firstErrBeat <= beatCount;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= RUN;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        flush     = 1'b0;
        endAck    = 1'b0;
        passOut   = 1'b0;
        case (state)
            RUN: begin
                if (sb.end_req)
                    stateNext = DRAIN;
            end
            DRAIN: begin
                if (fifoEmpty) begin
                    stateNext = DONE;
                end else if (timeoutHit) begin
                    // Stuck DUT: drop remaining expectations so the next
                    // vector starts clean.
                    stateNext = DONE;
                    flush     = 1'b1;
                end
            end
            DONE: begin
                endAck    = 1'b1;
                passOut   = !errSticky;
                stateNext = RUN;
            end
            default: stateNext = RUN;
        endcase
    end

    assign sb.exp_ready      = expReady;
    assign sb.obs_tready     = obsReady;
    assign sb.end_ack        = endAck;
    assign sb.pass           = passOut;
    assign sb.err_sticky     = errSticky;
    assign sb.err_count      = errCount;
    assign sb.beat_count     = beatCount;
    assign sb.first_err_beat = firstErrBeat;
    assign sb.timeout        = timeoutFlag;
endmodule
